cic_capture_ctrl: RTL
=====================

# cic_capture_ctrl

Capture controller that sequences the CIC decimation datapath. It restarts the filter and generates the decimation dump strobe at a run-time ratio. It discards the filter's settling outputs, then captures a programmed number of samples into a 4-entry output FIFO with a valid/ready interface. It sits between the CIC filter and the downstream sample consumer (DMA/serializer) and reports overflow when the consumer stalls.

## Interface
- WIDTH, 32, sample width; matches the CIC output width.
- DECIM_W, 9, width of the decimation-ratio input; supports ratios up to 511.
- SETTLE, 4, number of CIC outputs discarded after a clear; set to the filter's stage count.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low; one clock domain
- start  in  1  one-cycle pulse; begins a capture; honoured only in IDLE
- stop  in  1  one-cycle pulse; ends capture early
- decim_ratio  in  DECIM_W  decimation ratio; latched on an accepted start
- num_samples  in  16  samples to deliver; latched on start; 0 = continuous until stop
- cic_clear  out  1  one-cycle clear to the CIC datapath
- cic_dump  out  1  one-cycle decimation strobe to the CIC comb section
- cic_data  in  WIDTH  CIC output; valid the cycle after cic_dump
- out_data  out  WIDTH  head of FIFO
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts when out_valid && out_ready
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a capture completes
- overflow  out  1  sticky; a captured sample was dropped
- ovf_count  out  8  dropped-sample count (see Configuration)

## Operation
- States:
  - IDLE: idle; waits for start.
  - CLEAR: 1 cycle; drives cic_clear=1.
  - SETTLE: discards SETTLE samples.
  - RUN: captures samples.
  - DRAIN: waits until the FIFO is empty, then pulses done.
- IDLE→CLEAR on start && !stop. On the same edge:
  - latch ratio; a ratio below 2 is clamped to 2.
  - latch num_samples.
  - clear overflow, ovf_count and the sample counter.
- CLEAR→SETTLE unconditionally. The decimation counter resets to 0 on entry.
- Decimation counter, active in SETTLE and RUN:
  - counts 0..ratio-1; cic_dump=1 when it equals ratio-1, then it wraps to 0.
  - A dump period is therefore exactly `ratio` cycles.
- Sample event = the cycle after cic_dump. cic_data is registered on that cycle.
- SETTLE: sample events increment the discard count. After the SETTLE-th event, go to RUN; that SETTLE-th sample is not captured.
- RUN: each sample event pushes cic_data into the FIFO and increments the captured count.
  - A push while full drops the sample; overflow=1 and ovf_count saturates at 255.
  - A push is accepted when full if a pop happens in the same cycle.
  - Dropped samples still count toward num_samples.
  - After the num_samples-th event (num_samples≠0), go to DRAIN. cic_dump stops.
- stop in SETTLE, RUN or CLEAR → DRAIN next cycle. A sample event coinciding with stop is still captured.
- DRAIN→IDLE when the FIFO is empty; done=1 on that transition cycle.
- start outside IDLE is ignored. decim_ratio and num_samples changes mid-capture have no effect.
- FIFO contents persist into IDLE only until drained. No flush on completion.

## Timing
- Reset values:
  - state IDLE.
  - cic_clear, cic_dump, out_valid, busy, done, overflow = 0.
  - out_data = 0, ovf_count = 0, FIFO empty.
- start at edge N: cic_clear=1 in cycle N+1; first cic_dump in cycle N+1+ratio.
- FIFO push at a sample event → out_valid=1 the following cycle (1-cycle latency). out_data is stable while out_valid && !out_ready.
- Reset mid-operation returns everything to reset values immediately. The CIC is not cleared until the next start.

## Configuration
- CIC_CTRL_OVF_COUNT_EN defined: the 8-bit saturating ovf_count is implemented.
- Not defined: ovf_count is tied to 0. The sticky overflow flag is always present.

## Structure
- Shared package cic_ctrl_pkg:
  - state enum (IDLE, CLEAR, SETTLE, RUN, DRAIN).
  - minimum-ratio constant (2).
  - ovf_count width (8).
- One sub-module: cic_ctrl_fifo, a synchronous FIFO with FIFO_DEPTH entries, push/pop, full/empty and simultaneous push+pop when full.

## Test plan
- ratio=4, num_samples=3, out_ready=1: cic_clear in cycle 1 and dumps every 4 cycles; 4 discarded samples, then 3 FIFO outputs; done pulses once and busy drops.
- ratio=0: behaves as ratio 2, with cic_dump every 2nd cycle.
- ratio=2, num_samples=10, out_ready=0: FIFO holds 4 entries; overflow=1, ovf_count=6 (0 without the macro); done only after out_ready is raised and 4 pops complete.
- num_samples=0, stop after 5 captured samples: DRAIN; exactly 5 samples delivered, then done.
- start during RUN ignored; start&&stop in IDLE ignored; stop during SETTLE → done with 0 samples.
- rst_n low mid-RUN: all outputs at reset values asynchronously; a new start works normally.

Source files
------------

// File: rtl/cic_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cic_ctrl_pkg
// Shared definitions for the CIC capture controller: controller state
// encoding, the smallest usable decimation ratio, and the width of the
// dropped-sample counter.
// ---------------------------------------------------------------------------
package cic_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_RUN,
        S_DRAIN
    } state_t;

    // Ratios below this are clamped up; a ratio of 1 would dump every cycle,
    // which the comb section cannot follow.
    localparam int MIN_RATIO = 2;

    localparam int OVF_W = 8;

endpackage

// File: rtl/cic_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// cic_ctrl_fifo
// Synchronous FIFO holding captured CIC samples for the downstream consumer.
// A push while full is accepted only if a pop happens in the same cycle.
// rdata is the head entry; it reads as zero while the FIFO is empty.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write request and data
//   pop          read request (ignored while empty)
//   rdata        head of FIFO
//   full, empty  occupancy flags
// ---------------------------------------------------------------------------
module cic_ctrl_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: the storage array is deliberately not reset; the pointers define
    // which entries are valid, so resetting the data would only add logic.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cic_capture_ctrl.sv
// ---------------------------------------------------------------------------
// cic_capture_ctrl
// Sequences the CIC decimation datapath: clears the filter, generates the
// dump strobe at a run-time ratio, discards the SETTLE settling outputs, then
// captures num_samples samples (0 = until stop) into an output FIFO with a
// valid/ready interface. Samples arriving while the FIFO is full are dropped
// and reported through a sticky overflow flag.
//
// Build option: define CIC_CTRL_OVF_COUNT_EN to implement the 8-bit
// saturating dropped-sample counter; otherwise ovf_count is tied to 0.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start, stop   one-cycle capture start / early-stop pulses
//   decim_ratio   decimation ratio, latched on an accepted start
//   num_samples   samples to deliver, latched on start (0 = continuous)
//   cic_clear     one-cycle clear to the CIC datapath
//   cic_dump      decimation strobe to the CIC comb section
//   cic_data      CIC output, valid the cycle after cic_dump
//   out_data, out_valid, out_ready   FIFO head with valid/ready handshake
//   busy, done    capture in progress / one-cycle completion pulse
//   overflow      sticky dropped-sample flag
//   ovf_count     saturating dropped-sample count
// ---------------------------------------------------------------------------
module cic_capture_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DECIM_W    = 9,
    parameter int SETTLE     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [DECIM_W-1:0] decim_ratio,
    input  logic [15:0]        num_samples,
    output logic               cic_clear,
    output logic               cic_dump,
    input  logic [WIDTH-1:0]   cic_data,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [OVF_W-1:0]   ovf_count
);

    state_t             state;
    state_t             state_nxt;
    logic [DECIM_W-1:0] ratio_q;
    logic [DECIM_W-1:0] dec_cnt;
    logic [15:0]        num_q;
    logic [15:0]        evt_cnt;
    logic               dump_q;
    logic               start_ok;
    logic               sample_evt;
    logic               last_settle;
    logic               last_sample;
    logic               fifo_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic               drop;

    assign start_ok    = (state == S_IDLE) && start && !stop;
    // The CIC output is valid the cycle after a dump.
    assign sample_evt  = dump_q && (state == S_SETTLE || state == S_RUN);
    assign last_settle = sample_evt && (state == S_SETTLE) &&
                         (evt_cnt == 16'(SETTLE - 1));
    assign last_sample = sample_evt && (state == S_RUN) && (num_q != 16'd0) &&
                         (evt_cnt == num_q - 16'd1);

    // ---- state register ----------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---- next-state logic --------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_ok) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = stop ? S_DRAIN : S_SETTLE;
            S_SETTLE: begin
                if (stop)             state_nxt = S_DRAIN;
                else if (last_settle) state_nxt = S_RUN;
            end
            S_RUN:    if (stop || last_sample) state_nxt = S_DRAIN;
            S_DRAIN:  if (fifo_empty) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // ---- output logic ------------------------------------------------------
    // NOTE: every output gets a default before the case so no latch is
    // inferred for states that do not mention it.
    always_comb begin
        cic_clear = 1'b0;
        cic_dump  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_CLEAR: begin
                cic_clear = 1'b1;
                busy      = 1'b1;
            end
            S_SETTLE, S_RUN: begin
                busy     = 1'b1;
                cic_dump = (dec_cnt == ratio_q - DECIM_W'(1));
            end
            S_DRAIN: begin
                busy = 1'b1;
                done = fifo_empty;
            end
            default: ;
        endcase
    end

    // ---- datapath registers ------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ratio_q  <= DECIM_W'(MIN_RATIO);
            num_q    <= '0;
            dec_cnt  <= '0;
            evt_cnt  <= '0;
            dump_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            dump_q <= cic_dump;
            if (start_ok) begin
                ratio_q  <= (decim_ratio < DECIM_W'(MIN_RATIO)) ?
                            DECIM_W'(MIN_RATIO) : decim_ratio;
                num_q    <= num_samples;
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
            // Decimation counter starts from 0 on entry to SETTLE.
            if (state == S_CLEAR) begin
                dec_cnt <= '0;
            end else if (state == S_SETTLE || state == S_RUN) begin
                dec_cnt <= cic_dump ? '0 : dec_cnt + DECIM_W'(1);
            end
            // One event counter serves both phases: discards, then captures.
            if (start_ok || last_settle) begin
                evt_cnt <= '0;
            end else if (sample_evt) begin
                evt_cnt <= evt_cnt + 16'd1;
            end
        end
    end

    // ---- output FIFO -------------------------------------------------------
    assign fifo_push = sample_evt && (state == S_RUN);
    // Full implies non-empty, so a ready consumer always frees a slot.
    assign drop      = fifo_push && fifo_full && !out_ready;
    assign out_valid = !fifo_empty;

    cic_ctrl_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (cic_data),
        .pop   (out_ready),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef CIC_CTRL_OVF_COUNT_EN
    logic [OVF_W-1:0] ovf_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else if (start_ok) begin
            ovf_cnt_q <= '0;
        end else if (drop && (ovf_cnt_q != '1)) begin
            ovf_cnt_q <= ovf_cnt_q + OVF_W'(1);
        end
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = '0;
`endif

endmodule
